// File: rtl/ser_load_driver.sv
// Serializes a parallel word MSB-first into a downstream D flop's d/en_al pins.
// Optional SER_LOAD_PARITY_EN appends an even-parity bit after the LSB.
module ser_load_driver #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             hold_in,
  output logic             d_out,
  output logic             en_al_out,
  output logic             busy_out,
  output logic             done_out
);

`ifdef SER_LOAD_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int BW = $clog2(NB + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [NB-2:0]   shreg_q, shreg_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            d_q, d_d;
  logic            en_q, en_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            present;
  logic [NB-2:0]   load_rest;

`ifdef SER_LOAD_PARITY_EN
  assign load_rest = {data_in[WIDTH-2:0], ^data_in};
`else
  assign load_rest = data_in[WIDTH-2:0];
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    d_d     = d_q;
    en_d    = en_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    present = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        en_d    = 1'b1;
        busy_d  = 1'b0;
        if (valid_in && ready_q) begin
          d_d     = data_in[WIDTH-1];
          shreg_d = load_rest;
          bit_d   = BW'(1);
          gap_d   = '0;
          en_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // en_q low means the current bit is captured downstream at this edge;
        // en_q high means a bit is pending after a hold.
        if (!en_q) begin
          if (bit_q == BW'(NB)) begin
            state_d = ST_IDLE;
            en_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            en_d    = 1'b1;
            gap_d   = '0;
          end else if (hold_in) begin
            en_d = 1'b1;
          end else begin
            present = 1'b1;
          end
        end else if (!hold_in) begin
          present = 1'b1;
        end
      end
      ST_GAP: begin
        if (!hold_in) begin
          if (gap_q == GW'(GAP - 1)) present = 1'b1;
          else gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (present) begin
      d_d     = shreg_q[NB-2];
      shreg_d = shreg_q << 1;
      bit_d   = bit_q + BW'(1);
      en_d    = 1'b0;
      state_d = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      d_q     <= d_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_out = ready_q;
  assign d_out     = d_q;
  assign en_al_out = en_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_ser_load_driver.sv
// Directed bench for ser_load_driver: frame vectors on GAP=0 and GAP=2 instances
// plus a mid-frame reset sequence. Honours SER_LOAD_PARITY_EN.
module tb_ser_load_driver;
  localparam int W = 8;
`ifdef SER_LOAD_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] data;
  logic         valid0, valid2, hold;
  logic         rdy0, d0, en0, busy0, done0;
  logic         rdy2, d2, en2, busy2, done2;

  ser_load_driver #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .reset_al_in(rst_n), .data_in(data), .valid_in(valid0),
    .ready_out(rdy0), .hold_in(hold), .d_out(d0), .en_al_out(en0),
    .busy_out(busy0), .done_out(done0)
  );

  ser_load_driver #(.WIDTH(W), .GAP(2)) dut2 (
    .clk(clk), .reset_al_in(rst_n), .data_in(data), .valid_in(valid2),
    .ready_out(rdy2), .hold_in(hold), .d_out(d2), .en_al_out(en2),
    .busy_out(busy2), .done_out(done2)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           gap2;
    int           hold_after;
    int           hold_len;
    bit           noise;
    bit           chain;
    logic [W-1:0] exp_word;
    bit           exp_par;
    int           exp_span;
    int           exp_done;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input bit pre, input logic [W-1:0] next_data,
                         input bit next_gap2);
    int c, strobes, first, last, done_c, hold_rem, ef, span, expdone, extra;
    logic [15:0] got;
    bit sen, sd, sdone, srdy, sbusy, hold_started;
    extra   = PAR ? (1 + (v.gap2 ? 2 : 0)) : 0;
    span    = v.exp_span + extra;
    expdone = v.exp_done + extra;
    ef      = PAR ? ((int'(v.exp_word) << 1) | int'(v.exp_par)) : int'(v.exp_word);
    if (!pre) begin
      @(negedge clk);
      check("ready_before_accept", int'(v.gap2 ? rdy2 : rdy0), 1);
      data   = v.data;
      valid0 = !v.gap2;
      valid2 = v.gap2;
    end
    got = '0; strobes = 0; first = 0; last = 0; done_c = 0;
    hold_rem = 0; hold_started = 1'b0;
    for (c = 1; c <= 200 && done_c == 0; c++) begin
      @(negedge clk);
      sen   = v.gap2 ? en2 : en0;
      sd    = v.gap2 ? d2 : d0;
      sdone = v.gap2 ? done2 : done0;
      srdy  = v.gap2 ? rdy2 : rdy0;
      sbusy = v.gap2 ? busy2 : busy0;
      if (c == 1) begin
        check("busy_first", int'(sbusy), 1);
        check("ready_first", int'(srdy), 0);
      end
      if (!sen) begin
        got = {got[14:0], sd};
        strobes++;
        if (first == 0) first = c;
        last = c;
      end
      if (sdone) begin
        done_c = c;
        check("ready_at_done", int'(srdy), 1);
        check("busy_at_done", int'(sbusy), 0);
        check("en_at_done", int'(sen), 1);
        valid0 = 1'b0; valid2 = 1'b0; hold = 1'b0;
        if (v.chain) begin
          data   = next_data;
          valid0 = !next_gap2;
          valid2 = next_gap2;
        end
      end else begin
        if (!sen && strobes == v.hold_after && v.hold_len > 0 && !hold_started) begin
          hold_started = 1'b1;
          hold_rem     = v.hold_len;
        end
        if (hold_rem > 0) begin
          hold = 1'b1;
          hold_rem--;
        end else hold = 1'b0;
        if (v.noise) begin
          data   = '0;
          valid0 = !v.gap2;
          valid2 = v.gap2;
        end else begin
          valid0 = 1'b0;
          valid2 = 1'b0;
        end
      end
    end
    if (done_c == 0) $display("FAIL done_timeout: no done_out within 200 cycles");
    check("done_seen", int'(done_c != 0), 1);
    check("strobes", strobes, NB);
    check("bits", int'(got), ef);
    check("first_strobe", first, 1);
    check("span", last - first + 1, span);
    check("done_cycle", done_c, expdone);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ni, cnt;
    bit hit, seen_done;
    vecs[0] = '{8'hA5, 1'b0, 0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 8, 9};
    vecs[1] = '{8'hC3, 1'b1, 0, 0, 1'b0, 1'b0, 8'hC3, 1'b0, 22, 23};
    vecs[2] = '{8'hFF, 1'b0, 3, 3, 1'b0, 1'b0, 8'hFF, 1'b0, 11, 12};
    vecs[3] = '{8'h3C, 1'b0, 0, 0, 1'b1, 1'b1, 8'h3C, 1'b0, 8, 9};
    vecs[4] = '{8'h07, 1'b0, 0, 0, 1'b0, 1'b0, 8'h07, 1'b1, 8, 9};

    rst_n = 1'b0; valid0 = 1'b0; valid2 = 1'b0; hold = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    check("rst_en0", int'(en0), 1);
    check("rst_d0", int'(d0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_ready0", int'(rdy0), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_en2", int'(en2), 1);
    check("rst_ready2", int'(rdy2), 0);
    rst_n = 1'b1;
    #1 check("ready_at_release", int'(rdy0), 0);
    @(negedge clk);
    check("ready_after_edge", int'(rdy0), 1);
    check("ready2_after_edge", int'(rdy2), 1);

    for (int i = 0; i < NV; i++) begin
      ni = (i < NV - 1) ? i + 1 : i;
      run_vec(vecs[i], (i > 0) && vecs[i-1].chain, vecs[ni].data, vecs[ni].gap2);
    end

    // Reset during the 4th bit of a frame on the GAP=0 instance.
    @(negedge clk);
    data = 8'hFF; valid0 = 1'b1;
    cnt = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      valid0 = 1'b0;
      if (!en0) cnt++;
      if (cnt == 4) begin
        hit = 1'b1;
        check("d_before_reset", int'(d0), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_en", int'(en0), 1);
        check("midrst_d", int'(d0), 0);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_done", int'(done0), 0);
        check("midrst_ready", int'(rdy0), 0);
      end
    end
    if (!hit) $display("FAIL midrst_timeout: 4th strobe not seen");
    check("midrst_reached", int'(hit), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready_release", int'(rdy0), 0);
    seen_done = 1'b0;
    @(negedge clk);
    check("midrst_ready_edge", int'(rdy0), 1);
    for (int c = 0; c < 12; c++) begin
      if (done0 || !en0) seen_done = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done_or_strobe", int'(seen_done), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ser_load_driver.md
Name: ser_load_driver

Overview:
- Upstream feeder for a single-bit D flip-flop with synchronous active-low reset and active-low load enable.
- Takes a parallel word over a valid/ready handshake and serializes it MSB-first on d_out.
- Strobes en_al_out low for exactly one clock per bit so the downstream flop captures each bit once.
- Inserts programmable idle gaps between bits and supports a pause input.

Parameters:
WIDTH  8  bits per word (>=2)
GAP  0  idle cycles (en_al_out high) inserted between consecutive bits; 0 = back-to-back bits

Ports:
clk  input  1  rising-edge clock
reset_al_in  input  1  asynchronous active-low reset
data_in  input  WIDTH  parallel word to serialize
valid_in  input  1  data_in valid (active high)
ready_out  output  1  block can accept a word (active high)
hold_in  input  1  pause: freeze the frame while high
d_out  output  1  serial bit to downstream flop d_in
en_al_out  output  1  active-low load enable to downstream flop en_in
busy_out  output  1  frame in progress
done_out  output  1  one-cycle pulse when frame finishes

Behaviour:
- Reset is asynchronous and active-low on reset_al_in; the block is clocked by the single clock clk.
- While reset_al_in=0: state=IDLE, ready_out=0, d_out=0, en_al_out=1, busy_out=0, done_out=0, shift/bit/gap counters=0.
- ready_out rises on the first rising edge after reset release.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - ready_out=1, en_al_out=1, d_out holds its last value.
  - Accept occurs when valid_in=1 and ready_out=1 at an edge: the word is latched, ready_out->0, busy_out->1, state->SHIFT.
  - In the cycle after the accepting edge: d_out=data_in[WIDTH-1], en_al_out=0.
- SHIFT:
  - en_al_out=0 for exactly one cycle per bit; bits go out MSB first.
  - After a non-final bit: if GAP>0, go to GAP (en_al_out=1, d_out holds); else present the next bit in the next cycle.
- GAP:
  - Count GAP cycles with en_al_out=1, then return to SHIFT with the next bit.
- Frame end:
  - After the final bit's enable cycle, go to IDLE. No trailing gap.
  - In that cycle: en_al_out=1, ready_out=1, busy_out=0, done_out=1 (exactly one cycle).
  - A word may be accepted in the done_out cycle. The minimum spacing between frames is therefore one cycle with en_al_out high.
- Frame duration: N bits take N + (N-1)*GAP cycles from the first en_al_out low to the last.
- hold_in=1 during SHIFT or GAP:
  - The next-cycle en_al_out is forced to 1.
  - Bit index and gap counter freeze; d_out holds.
  - On release, the pending bit is presented with en_al_out=0. No bit is skipped or duplicated.
  - hold_in is ignored in IDLE.
- valid_in while busy: ignored; data_in is not sampled and the in-flight frame is unaffected.
- Reset asserted mid-frame: outputs go immediately to reset values and the partial frame is discarded. No done_out.
- Counter widths: bit index uses clog2(WIDTH+1); gap counter uses max(1, clog2(GAP+1)).

Optional Feature:
- Macro: SER_LOAD_PARITY_EN
- Defined:
  - An even-parity bit (XOR of all WIDTH latched bits) is appended after the LSB, giving a frame of WIDTH+1 enable strobes.
  - GAP applies before the parity bit as before any other bit.
  - done_out follows the parity bit.
- Undefined: frame is exactly WIDTH bits; no parity logic is synthesized.

Test Plan:
- WIDTH=8, GAP=0, accept 8'hA5 -> en_al_out low for 8 consecutive cycles; d_out=1,0,1,0,0,1,0,1; done_out=1 on the 9th cycle after accept, with ready_out=1 simultaneously.
- GAP=2, 8'hC3 -> en_al_out pattern L,H,H repeated, ending L; 22 cycles from first L to last L; d_out=1,1,0,0,0,0,1,1 on the L cycles.
- GAP=0, 8'hFF, hold_in high for 3 cycles after the 3rd bit -> en_al_out high exactly those 3 cycles; 8 total low strobes; done_out delayed by 3 cycles.
- Accept 8'h3C, drive valid_in with 8'h00 during the frame -> serial output still 0,0,1,1,1,1,0,0; back-to-back word accepted in the done_out cycle starts 1 cycle later.
- reset_al_in pulsed low at the 4th bit -> same-cycle en_al_out=1, d_out=0, busy_out=0; no done_out; ready_out=1 one edge after release.
- SER_LOAD_PARITY_EN defined: 8'hA5 -> 9 strobes, 9th d_out=0; 8'h07 -> 9th d_out=1.
